// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: in-order writeback FIFO that takes ALU and load results and
// retires up to two of them per cycle on the register file's Rd and Rs write ports.
// Build option: WBQ_COALESCE_EN. When defined, an equal-address head pair drops the
// older write and retires only the younger one on Rs. Otherwise the pair is split
// across two cycles.
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Alu_Valid,
    input  logic [AW-1:0]     Alu_Addr,
    input  logic [DW-1:0]     Alu_Data,
    output logic              Alu_Ready,
    input  logic              Ld_Valid,
    input  logic [AW-1:0]     Ld_Addr,
    input  logic [DW-1:0]     Ld_Data,
    output logic              Ld_Ready,
    output logic              Rd_Wen,
    output logic [AW-1:0]     Rd_Addr,
    output logic [DW-1:0]     Rd_Data,
    output logic              Rs_Wen,
    output logic [AW-1:0]     Rs_Addr,
    output logic [DW-1:0]     Rs_Data,
    output logic [2**AW-1:0]  Busy_Mask
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] LD_MAX_CNT = CW'(DEPTH - 2);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    head_nxt1;
    logic [PW-1:0]    ld_slot;
    logic [CW-1:0]    count;
    logic             alu_push;
    logic             ld_push;
    logic [1:0]       push_cnt;
    logic [1:0]       pop_cnt;
    logic [DEPTH-1:0] entry_valid;

    // The ALU keeps the last free slot; a load needs room for both producers.
    assign Alu_Ready = (count != FULL_CNT);
    assign Ld_Ready  = (count <= LD_MAX_CNT);
    assign alu_push  = Alu_Valid && Alu_Ready;
    assign ld_push   = Ld_Valid && Ld_Ready;
    assign push_cnt  = {1'b0, alu_push} + {1'b0, ld_push};

    // A load goes behind a same-cycle ALU result, so the ALU entry counts as older.
    assign ld_slot   = alu_push ? (tail + PW'(1)) : tail;
    assign head_nxt1 = head + PW'(1);

    assign Rd_Addr = addr_q[head];
    assign Rd_Data = data_q[head];
    assign Rs_Addr = addr_q[head_nxt1];
    assign Rs_Data = data_q[head_nxt1];

    // Retire selection from the two oldest entries.
    always_comb begin
        Rd_Wen  = 1'b0;
        Rs_Wen  = 1'b0;
        pop_cnt = 2'd0;
        if (count == CW'(1)) begin
            Rd_Wen  = 1'b1;
            pop_cnt = 2'd1;
        end else if (count >= CW'(2)) begin
            if (Rd_Addr != Rs_Addr) begin
                Rd_Wen  = 1'b1;
                Rs_Wen  = 1'b1;
                pop_cnt = 2'd2;
            end else begin
`ifdef WBQ_COALESCE_EN
                Rs_Wen  = 1'b1;
                pop_cnt = 2'd2;
`else
                Rd_Wen  = 1'b1;
                pop_cnt = 2'd1;
`endif
            end
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_valid
        logic [PW-1:0] offs;
        assign offs           = PW'(g) - head;
        assign entry_valid[g] = ({{(CW-PW){1'b0}}, offs} < count);
    end

    // Busy mask marks every register with at least one pending write.
    always_comb begin
        Busy_Mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                Busy_Mask[addr_q[i]] = 1'b1;
            end
        end
    end

    // Pointer, occupancy and storage update; reset discards everything, including pushes.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alu_push) begin
                addr_q[tail] <= Alu_Addr;
                data_q[tail] <= Alu_Data;
            end
            if (ld_push) begin
                addr_q[ld_slot] <= Ld_Addr;
                data_q[ld_slot] <= Ld_Data;
            end
            head  <= head + PW'(pop_cnt);
            tail  <= tail + PW'(push_cnt);
            count <= count + CW'(push_cnt) - CW'(pop_cnt);
        end
    end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Alu_Valid;
    logic [3:0]  Alu_Addr;
    logic [15:0] Alu_Data;
    logic        Alu_Ready;
    logic        Ld_Valid;
    logic [3:0]  Ld_Addr;
    logic [15:0] Ld_Data;
    logic        Ld_Ready;
    logic        Rd_Wen;
    logic [3:0]  Rd_Addr;
    logic [15:0] Rd_Data;
    logic        Rs_Wen;
    logic [3:0]  Rs_Addr;
    logic [15:0] Rs_Data;
    logic [15:0] Busy_Mask;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    typedef struct {
        logic        av;
        logic [3:0]  aa;
        logic [15:0] ad;
        logic        lv;
        logic [3:0]  la;
        logic [15:0] ld;
        logic        rdw;
        logic [3:0]  rda;
        logic [15:0] rdd;
        logic        rsw;
        logic [3:0]  rsa;
        logic [15:0] rsd;
        logic [15:0] busy;
    } vec_t;

    ent_t mq[$];
    vec_t vecs[$];
    vec_t none;

    reg_writeback_queue #(.DEPTH(DEPTH), .AW(4), .DW(16)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Alu_Valid(Alu_Valid), .Alu_Addr(Alu_Addr), .Alu_Data(Alu_Data), .Alu_Ready(Alu_Ready),
        .Ld_Valid(Ld_Valid), .Ld_Addr(Ld_Addr), .Ld_Data(Ld_Data), .Ld_Ready(Ld_Ready),
        .Rd_Wen(Rd_Wen), .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data),
        .Rs_Wen(Rs_Wen), .Rs_Addr(Rs_Addr), .Rs_Data(Rs_Data),
        .Busy_Mask(Busy_Mask)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic av, logic [3:0] aa, logic [15:0] ad,
                                logic lv, logic [3:0] la, logic [15:0] ld,
                                logic rdw, logic [3:0] rda, logic [15:0] rdd,
                                logic rsw, logic [3:0] rsa, logic [15:0] rsd,
                                logic [15:0] busy);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.lv = lv; v.la = la; v.ld = ld;
        v.rdw = rdw; v.rda = rda; v.rdd = rdd;
        v.rsw = rsw; v.rsa = rsa; v.rsd = rsd;
        v.busy = busy;
        return v;
    endfunction

    task automatic drive(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                         input logic lv, input logic [3:0] la, input logic [15:0] ld);
        Alu_Valid = av; Alu_Addr = aa; Alu_Data = ad;
        Ld_Valid  = lv; Ld_Addr  = la; Ld_Data  = ld;
    endtask

    // One cycle: compare outputs against the model (and optionally a table row),
    // then advance the model across the rising edge.
    task automatic step(input bit use_vec, input vec_t v);
        int          n;
        int          pops;
        logic        e_ar, e_lr, e_rdw, e_rsw;
        ent_t        e_rd, e_rs;
        logic [15:0] e_busy;
        @(negedge Clock);
        n      = mq.size();
        e_ar   = (n < DEPTH);
        e_lr   = (n <= DEPTH - 2);
        e_busy = '0;
        foreach (mq[i]) e_busy[mq[i].a] = 1'b1;
        e_rdw = 1'b0; e_rsw = 1'b0; pops = 0;
        e_rd  = '0;   e_rs  = '0;
        if (n == 1) begin
            e_rdw = 1'b1; e_rd = mq[0]; pops = 1;
        end else if (n >= 2) begin
            if (mq[0].a != mq[1].a) begin
                e_rdw = 1'b1; e_rd = mq[0];
                e_rsw = 1'b1; e_rs = mq[1]; pops = 2;
            end else begin
`ifdef WBQ_COALESCE_EN
                e_rsw = 1'b1; e_rs = mq[1]; pops = 2;
`else
                e_rdw = 1'b1; e_rd = mq[0]; pops = 1;
`endif
            end
        end
        chk("alu_ready", 32'(Alu_Ready), 32'(e_ar));
        chk("ld_ready",  32'(Ld_Ready),  32'(e_lr));
        chk("rd_wen",    32'(Rd_Wen),    32'(e_rdw));
        chk("rs_wen",    32'(Rs_Wen),    32'(e_rsw));
        chk("busy_mask", 32'(Busy_Mask), 32'(e_busy));
        if (e_rdw) chk("rd_entry", 32'({Rd_Addr, Rd_Data}), 32'(e_rd));
        if (e_rsw) chk("rs_entry", 32'({Rs_Addr, Rs_Data}), 32'(e_rs));
        if (use_vec) begin
            chk("vec_rd_wen", 32'(Rd_Wen), 32'(v.rdw));
            chk("vec_rs_wen", 32'(Rs_Wen), 32'(v.rsw));
            chk("vec_busy",   32'(Busy_Mask), 32'(v.busy));
            if (v.rdw) chk("vec_rd_entry", 32'({Rd_Addr, Rd_Data}), 32'({v.rda, v.rdd}));
            if (v.rsw) chk("vec_rs_entry", 32'({Rs_Addr, Rs_Data}), 32'({v.rsa, v.rsd}));
        end
        @(posedge Clock);
        if (!Reset_n) begin
            mq.delete();
        end else begin
            repeat (pops) void'(mq.pop_front());
            if (Alu_Valid && e_ar) mq.push_back({Alu_Addr, Alu_Data});
            if (Ld_Valid && e_lr)  mq.push_back({Ld_Addr, Ld_Data});
        end
        #1;
    endtask

    initial begin
        none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Directed table: inputs applied this cycle, outputs expected before the edge.
        vecs.push_back(mk(1, 4'd3, 16'h1234, 0, 0, 0,          0, 0, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,                    1, 4'd3, 16'h1234, 0, 0, 0, 16'h0008));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 4'd5, 16'hAAAA, 1, 4'd6, 16'hBBBB, 0, 0, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,                    1, 4'd5, 16'hAAAA, 1, 4'd6, 16'hBBBB, 16'h0060));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 4'd2, 16'h0001, 1, 4'd2, 16'h0002, 0, 0, 0, 0, 0, 0, 16'h0000));
`ifdef WBQ_COALESCE_EN
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,                    0, 0, 0, 1, 4'd2, 16'h0002, 16'h0004));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 16'h0000));
`else
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,                    1, 4'd2, 16'h0001, 0, 0, 0, 16'h0004));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,                    1, 4'd2, 16'h0002, 0, 0, 0, 16'h0004));
`endif
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 16'h0000));

        Reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ld);
            step(1, vecs[i]);
        end

        // Both producers held valid for 8 cycles with distinct addresses.
        for (int i = 0; i < 8; i++) begin
            drive(1, 4'(2 * i), 16'(16'h1000 + i), 1, 4'(2 * i + 1), 16'(16'h2000 + i));
            step(0, none);
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) step(0, none);

        // Same-address pairs build occupancy; then load waits with changing data.
        drive(1, 4'd7, 16'h0701, 1, 4'd7, 16'h0702); step(0, none);
        drive(1, 4'd7, 16'h0703, 1, 4'd7, 16'h0704); step(0, none);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 4'd9, 16'(16'h0900 + i));
            step(0, none);
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (5) step(0, none);

        // Fill to three entries, reset mid-operation with pushes presented.
        drive(1, 4'd1, 16'h0101, 1, 4'd1, 16'h0102); step(0, none);
        drive(1, 4'd1, 16'h0103, 1, 4'd1, 16'h0104); step(0, none);
        Reset_n = 1'b0;
        drive(1, 4'd4, 16'hDEAD, 1, 4'd8, 16'hBEEF); step(0, none);
        Reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step(1, none);
        chk("post_reset_alu_ready", 32'(Alu_Ready), 32'd1);
        chk("post_reset_ld_ready",  32'(Ld_Ready),  32'd1);

        // Randomized traffic with a small address space to force collisions and stalls.
        for (int i = 0; i < 400; i++) begin
            Reset_n = ($urandom_range(0, 59) != 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), 16'($urandom),
                  $urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), 16'($urandom));
            step(0, none);
        end
        Reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) step(0, none);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
